// File: rtl/cpu_defs.sv
// ---------------------------------------------------------------------------
// cpu_defs
//   Shared CPU front-end types and constants.
//   fq_entry_t is one fetch-queue entry: fetch PC, instruction word and the
//   fetch-side exception flags that travel with it into decode.
//   FQ_* constants size the default fetch queue instance.
// ---------------------------------------------------------------------------
package cpu_defs;

    typedef enum logic [2:0] {
        TLB_NONE      = 3'd0,
        TLB_REFILL_L  = 3'd1,
        TLB_REFILL_S  = 3'd2,
        TLB_INVALID_L = 3'd3,
        TLB_INVALID_S = 3'd4,
        TLB_MOD       = 3'd5
    } tlb_exc_t;

    // The pad field rounds the entry up to 72 bits so the queue storage
    // lines up with the wider datapath word.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        addr_err_if;
        logic        in_delay_slot;
        tlb_exc_t    tlb_exc_if;
        logic [2:0]  pad;
    } fq_entry_t;

    localparam int FQ_DEPTH  = 8;
    localparam int FQ_PUSH_W = 2;
    localparam int FQ_POP_W  = 2;
    localparam int FQ_DATA_W = $bits(fq_entry_t);

endpackage

// File: rtl/fq_ptr.sv
// ---------------------------------------------------------------------------
// fq_ptr
//   Modulo-DEPTH pointer register that advances by 0..MAX_INC each cycle.
//   DEPTH is a power of two, so wrapping is plain binary overflow.
// Ports:
//   clk      clock
//   rst      synchronous active-high reset, pointer -> 0
//   i_clear  synchronous clear (flush), same effect as rst
//   i_inc    increment applied at the next clock edge
//   o_ptr    current pointer value
// ---------------------------------------------------------------------------
module fq_ptr #(
    parameter  int DEPTH   = 8,
    parameter  int MAX_INC = 2,
    localparam int PTR_W   = $clog2(DEPTH),
    localparam int INC_W   = $clog2(MAX_INC + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear,
    input  logic [INC_W-1:0] i_inc,
    output logic [PTR_W-1:0] o_ptr
);

    logic [PTR_W-1:0] r_ptr;

    // Pointer register: reset and flush both return it to slot 0, otherwise
    // it steps forward and wraps naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_ptr <= '0;
        end else begin
            r_ptr <= r_ptr + PTR_W'(i_inc);
        end
    end

    assign o_ptr = r_ptr;

endmodule

// File: rtl/fetch_queue.sv
// ---------------------------------------------------------------------------
// fetch_queue
//   Multi-lane circular instruction buffer between IF and ID. Fetch writes
//   up to PUSH_W entries per cycle, decode consumes up to POP_W entries per
//   cycle. All outputs come from registers only, so there is no combinational
//   path from any input to any output.
// Ports:
//   clk         clock
//   rst         synchronous active-high reset, empties the queue
//   flush       synchronous clear, wins over push and pop in the same cycle
//   push_valid  per-lane write enables, contiguous from lane 0
//   push_data   lane i at bits [i*DATA_W +: DATA_W]
//   push_ready  at least PUSH_W free entries (whole-group acceptance only)
//   out_valid   out_valid[i] = occupancy > i
//   out_data    lane i = entry at head+i
//   pop_cnt     number of head entries decode consumes this cycle
//   count       current occupancy
//   empty/full  occupancy == 0 / occupancy == DEPTH
// ---------------------------------------------------------------------------
module fetch_queue
    import cpu_defs::*;
#(
    parameter  int DEPTH  = FQ_DEPTH,
    parameter  int PUSH_W = FQ_PUSH_W,
    parameter  int POP_W  = FQ_POP_W,
    parameter  int DATA_W = FQ_DATA_W,
    localparam int CNT_W  = $clog2(DEPTH + 1),
    localparam int POPC_W = $clog2(POP_W + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic [PUSH_W-1:0]        push_valid,
    input  logic [PUSH_W*DATA_W-1:0] push_data,
    output logic                     push_ready,
    output logic [POP_W-1:0]         out_valid,
    output logic [POP_W*DATA_W-1:0]  out_data,
    input  logic [POPC_W-1:0]        pop_cnt,
    output logic [CNT_W-1:0]         count,
    output logic                     empty,
    output logic                     full
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int PUSHC_W = $clog2(PUSH_W + 1);

    logic [DATA_W-1:0]  r_mem [DEPTH];
    logic [CNT_W-1:0]   r_count;
    logic [PTR_W-1:0]   w_head;
    logic [PTR_W-1:0]   w_tail;
    logic [CNT_W-1:0]   w_free;
    logic               w_push_ready;
    logic               w_run;
    logic [PUSH_W-1:0]  w_lane_en;
    logic [PUSHC_W-1:0] w_npush;
    logic [POPC_W-1:0]  w_npop;

    // Free-slot test uses the registered occupancy only; a pop in the same
    // cycle does not open room for a push until the following cycle.
    always_comb begin
        w_free       = CNT_W'(DEPTH) - r_count;
        w_push_ready = (w_free >= CNT_W'(PUSH_W));
    end

    // Accepted lanes are the unbroken run of valid lanes starting at lane 0.
    // A valid lane after a gap is ignored, and nothing is taken at all when
    // the queue cannot hold a full PUSH_W group.
    always_comb begin
        w_run     = 1'b1;
        w_lane_en = '0;
        w_npush   = '0;
        for (int i = 0; i < PUSH_W; i++) begin
            w_run        = w_run & push_valid[i];
            w_lane_en[i] = w_run & w_push_ready;
            if (w_lane_en[i]) begin
                w_npush = PUSHC_W'(i + 1);
            end
        end
    end

    // Decode may ask for more than is buffered; clamp so popping from a
    // short or empty queue only removes what is actually there.
    always_comb begin
        if (r_count < CNT_W'(pop_cnt)) begin
            w_npop = POPC_W'(r_count);
        end else begin
            w_npop = pop_cnt;
        end
    end

    fq_ptr #(
        .DEPTH   (DEPTH),
        .MAX_INC (POP_W)
    ) u_head (
        .clk     (clk),
        .rst     (rst),
        .i_clear (flush),
        .i_inc   (w_npop),
        .o_ptr   (w_head)
    );

    fq_ptr #(
        .DEPTH   (DEPTH),
        .MAX_INC (PUSH_W)
    ) u_tail (
        .clk     (clk),
        .rst     (rst),
        .i_clear (flush),
        .i_inc   (w_npush),
        .o_ptr   (w_tail)
    );

    // Occupancy is kept in its own register rather than derived from the
    // pointers, so full and empty are distinguishable when head == tail.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + CNT_W'(w_npush) - CNT_W'(w_npop);
        end
    end

    // Entry storage has no reset; contents are only meaningful behind
    // out_valid. Lane i lands at tail+i so program order survives the wrap.
    always_ff @(posedge clk) begin
        if (!(rst || flush)) begin
            for (int i = 0; i < PUSH_W; i++) begin
                if (w_lane_en[i]) begin
                    r_mem[w_tail + PTR_W'(i)] <= push_data[i*DATA_W +: DATA_W];
                end
            end
        end
    end

    for (genvar g = 0; g < POP_W; g++) begin : g_out
        assign out_valid[g]                  = (r_count > CNT_W'(g));
        assign out_data[g*DATA_W +: DATA_W]  = r_mem[w_head + PTR_W'(g)];
    end

    assign push_ready = w_push_ready;
    assign count      = r_count;
    assign empty      = (r_count == '0);
    assign full       = (r_count == CNT_W'(DEPTH));

    // Simulation-only sanity checks on occupancy and on the decode and fetch
    // handshakes. A gapped lane mask is reported but tolerated, since the
    // queue already ignores the stray lane.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (r_count <= CNT_W'(DEPTH))
                else $error("fetch_queue: occupancy above DEPTH");
            assert (pop_cnt <= POPC_W'(POP_W))
                else $error("fetch_queue: pop_cnt above POP_W");
            assert (((push_valid + PUSH_W'(1)) & push_valid) == '0)
                else $warning("fetch_queue: push_valid lanes not contiguous");
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// ---------------------------------------------------------------------------
// tb_fetch_queue
//   Directed bench for fetch_queue (DEPTH=8, PUSH_W=POP_W=2). A queue-level
//   reference model tracks the buffered entries; a negedge process compares
//   every output against it each cycle, and directed steps pin literal
//   expectations from hand-worked sequences.
// ---------------------------------------------------------------------------
module tb_fetch_queue;
    import cpu_defs::*;

    localparam int DEPTH  = 8;
    localparam int PUSH_W = 2;
    localparam int POP_W  = 2;
    localparam int DW     = FQ_DATA_W;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 flush;
    logic [PUSH_W-1:0]    push_valid;
    logic [PUSH_W*DW-1:0] push_data;
    logic                 push_ready;
    logic [POP_W-1:0]     out_valid;
    logic [POP_W*DW-1:0]  out_data;
    logic [1:0]           pop_cnt;
    logic [3:0]           count;
    logic                 empty;
    logic                 full;

    int compared   = 0;
    int mismatched = 0;

    logic [DW-1:0] mq[$];
    bit            modelLive = 1'b0;

    always #5 clk = ~clk;

    fetch_queue #(
        .DEPTH  (DEPTH),
        .PUSH_W (PUSH_W),
        .POP_W  (POP_W),
        .DATA_W (DW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .push_valid (push_valid),
        .push_data  (push_data),
        .push_ready (push_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .pop_cnt    (pop_cnt),
        .count      (count),
        .empty      (empty),
        .full       (full)
    );

    // Builds a recognisable entry from a serial number.
    function automatic logic [DW-1:0] mkEntry(input int n);
        fq_entry_t e;
        e.pc            = 32'h0040_0000 + 32'(n * 4);
        e.instr         = 32'h2400_0000 | 32'(n);
        e.addr_err_if   = n[0];
        e.in_delay_slot = n[1];
        e.tlb_exc_if    = tlb_exc_t'(3'(n % 6));
        e.pad           = '0;
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [DW-1:0] act,
                               input logic [DW-1:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Reference model: a FIFO of entries updated with the queue rules at
    // every rising edge, from the inputs present at that edge.
    always @(posedge clk) begin : modelUpd
        int sz;
        int np;
        int nq;
        bit rdy;
        if (rst || flush) begin
            mq.delete();
            modelLive = 1'b1;
        end else if (modelLive) begin
            sz  = mq.size();
            rdy = (DEPTH - sz) >= PUSH_W;
            np  = int'(pop_cnt);
            if (np > sz) np = sz;
            nq = 0;
            if (rdy && push_valid[0]) nq = push_valid[1] ? 2 : 1;
            repeat (np) void'(mq.pop_front());
            for (int i = 0; i < nq; i++) mq.push_back(push_data[i*DW +: DW]);
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin : cmpProc
        int sz;
        if (modelLive) begin
            sz = mq.size();
            checkOutput("cmp_count", DW'(count), DW'(sz));
            checkOutput("cmp_empty", DW'(empty), DW'(sz == 0));
            checkOutput("cmp_full", DW'(full), DW'(sz == DEPTH));
            checkOutput("cmp_push_ready", DW'(push_ready), DW'((DEPTH - sz) >= PUSH_W));
            for (int i = 0; i < POP_W; i++) begin
                checkOutput("cmp_out_valid", DW'(out_valid[i]), DW'(sz > i));
                if (sz > i) checkOutput("cmp_out_data", out_data[i*DW +: DW], mq[i]);
            end
        end
    end

    // One clock of stimulus: inputs applied, edge taken, outputs settled.
    task automatic applyStimulus(input logic r, input logic f, input logic [1:0] pv,
                                 input int n0, input int n1, input logic [1:0] pc);
        rst        = r;
        flush      = f;
        push_valid = pv;
        push_data  = {mkEntry(n1), mkEntry(n0)};
        pop_cnt    = pc;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stim
        int wPv[7];
        int wPop[7];
        int wCnt[7];
        int wHead[7];
        wPv   = '{3, 3, 3, 3, 3, 0, 0};
        wPop  = '{0, 1, 2, 1, 2, 2, 2};
        wCnt  = '{2, 3, 3, 4, 4, 2, 0};
        wHead = '{30, 31, 33, 34, 36, 38, 0};

        applyStimulus(1'b1, 1'b0, 2'b00, 0, 0, 2'd0);
        applyStimulus(1'b1, 1'b0, 2'b00, 0, 0, 2'd0);
        checkOutput("rst_count", DW'(count), DW'(0));
        checkOutput("rst_empty", DW'(empty), DW'(1));
        checkOutput("rst_full", DW'(full), DW'(0));
        checkOutput("rst_push_ready", DW'(push_ready), DW'(1));
        checkOutput("rst_out_valid", DW'(out_valid), DW'(0));

        // Fill to DEPTH with pairs
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b0, 1'b0, 2'b11, 2*k, 2*k+1, 2'd0);
            checkOutput("fill_count", DW'(count), DW'(2*k + 2));
        end
        checkOutput("fill_full", DW'(full), DW'(1));
        checkOutput("fill_push_ready", DW'(push_ready), DW'(0));
        checkOutput("fill_lane0", out_data[0 +: DW], mkEntry(0));
        checkOutput("fill_lane1", out_data[DW +: DW], mkEntry(1));

        // Drain two at a time in program order
        for (int k = 0; k < 4; k++) begin
            checkOutput("drain_lane0", out_data[0 +: DW], mkEntry(2*k));
            checkOutput("drain_lane1", out_data[DW +: DW], mkEntry(2*k+1));
            applyStimulus(1'b0, 1'b0, 2'b00, 0, 0, 2'd2);
        end
        checkOutput("drain_empty", DW'(empty), DW'(1));
        applyStimulus(1'b0, 1'b0, 2'b00, 0, 0, 2'd2);
        checkOutput("drain_extra_pop_count", DW'(count), DW'(0));

        // Advance head to 3, then run across the wrap point
        applyStimulus(1'b0, 1'b0, 2'b11, 20, 21, 2'd0);
        applyStimulus(1'b0, 1'b0, 2'b01, 22, 0, 2'd0);
        applyStimulus(1'b0, 1'b0, 2'b00, 0, 0, 2'd2);
        applyStimulus(1'b0, 1'b0, 2'b00, 0, 0, 2'd1);
        checkOutput("prepop_count", DW'(count), DW'(0));
        for (int k = 0; k < 7; k++) begin
            applyStimulus(1'b0, 1'b0, 2'(wPv[k]), 30 + 2*k, 31 + 2*k, 2'(wPop[k]));
            checkOutput("wrap_count", DW'(count), DW'(wCnt[k]));
            if (wCnt[k] > 0) checkOutput("wrap_lane0", out_data[0 +: DW], mkEntry(wHead[k]));
        end

        // Push refused at count 7 even while popping
        applyStimulus(1'b0, 1'b0, 2'b11, 40, 41, 2'd0);
        applyStimulus(1'b0, 1'b0, 2'b11, 42, 43, 2'd0);
        applyStimulus(1'b0, 1'b0, 2'b11, 44, 45, 2'd0);
        applyStimulus(1'b0, 1'b0, 2'b01, 46, 0, 2'd0);
        checkOutput("c7_count", DW'(count), DW'(7));
        checkOutput("c7_push_ready", DW'(push_ready), DW'(0));
        checkOutput("c7_full", DW'(full), DW'(0));
        applyStimulus(1'b0, 1'b0, 2'b11, 47, 48, 2'd2);
        checkOutput("c7_pushpop_count", DW'(count), DW'(5));
        checkOutput("c7_pushpop_ready", DW'(push_ready), DW'(1));
        checkOutput("c7_pushpop_lane0", out_data[0 +: DW], mkEntry(42));
        applyStimulus(1'b0, 1'b0, 2'b11, 49, 50, 2'd0);
        checkOutput("c7_refill_count", DW'(count), DW'(7));

        // Flush wins over same-cycle push and pop
        applyStimulus(1'b0, 1'b0, 2'b00, 0, 0, 2'd2);
        checkOutput("preflush_count", DW'(count), DW'(5));
        applyStimulus(1'b0, 1'b1, 2'b11, 60, 61, 2'd1);
        checkOutput("flush_count", DW'(count), DW'(0));
        checkOutput("flush_empty", DW'(empty), DW'(1));
        checkOutput("flush_out_valid", DW'(out_valid), DW'(0));

        // Gapped lane mask is ignored
        applyStimulus(1'b0, 1'b0, 2'b10, 69, 70, 2'd0);
        checkOutput("gap_count", DW'(count), DW'(0));
        checkOutput("gap_empty", DW'(empty), DW'(1));

        // Single entry, over-pop
        applyStimulus(1'b0, 1'b0, 2'b01, 80, 0, 2'd0);
        checkOutput("single_count", DW'(count), DW'(1));
        checkOutput("single_out_valid", DW'(out_valid), DW'(2'b01));
        checkOutput("single_lane0", out_data[0 +: DW], mkEntry(80));
        applyStimulus(1'b0, 1'b0, 2'b00, 0, 0, 2'd2);
        checkOutput("single_pop_count", DW'(count), DW'(0));
        checkOutput("single_pop_out_valid", DW'(out_valid), DW'(0));

        applyStimulus(1'b0, 1'b0, 2'b00, 0, 0, 2'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
